sign_window_3x3: RTL and testbench

Builds 3×3 sign windows for the binary convolution from the 3-row sign-column stream produced by the row-buffer/sign stage (the 2·LEN-bit `tdata_c` bus). Per channel it holds the two previous columns in channel-deep delay lines and emits one 9-tap window per (centre column, channel). It zero-pads the left and right image borders, so the XNOR/popcount stage downstream sees SIZE×CHANNEL windows per row. Vertical padding is already applied upstream.

---
 rtl/sign_win_pkg.sv | 15 +
 rtl/sign_window_3x3_if.sv | 29 ++
 rtl/chan_delay.sv | 26 ++
 rtl/sign_window_3x3.sv | 157 +++++++++++++++
 tb/tb_sign_window_3x3.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sign_win_pkg.sv
// Shared sign-code constants, FSM state type and code sanitiser for the 3x3 sign window builder.
package sign_win_pkg;

  localparam logic [1:0] SGN_ZERO = 2'b00;
  localparam logic [1:0] SGN_POS  = 2'b01;
  localparam logic [1:0] SGN_NEG  = 2'b11;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;

  // The unused code 2'b10 reads as zero so downstream never sees it.
  function automatic logic [1:0] sgn_clean(input logic [1:0] code);
    return ((code == SGN_POS) || (code == SGN_NEG)) ? code : SGN_ZERO;
  endfunction

endpackage

// File: rtl/sign_window_3x3_if.sv
// Sign-column input stream and 3x3 window output stream of sign_window_3x3.
interface sign_window_3x3_if #(
  parameter int unsigned CHANNEL = 64,
  parameter int unsigned LEN     = 3,
  parameter int unsigned CW      = $clog2(CHANNEL)
);
  logic                     i_vsync;
  logic                     i_hsync;
  logic                     i_reuse;
  logic                     i_valid;
  logic [2*LEN-1:0]         i_tdata;
  logic                     o_vsync;
  logic                     o_hsync;
  logic                     o_reuse;
  logic                     o_valid;
  logic [2*LEN*LEN-1:0]     o_window;
  logic [CW-1:0]            o_ch;
  logic                     o_err;

  modport master (
    output i_vsync, i_hsync, i_reuse, i_valid, i_tdata,
    input  o_vsync, o_hsync, o_reuse, o_valid, o_window, o_ch, o_err
  );

  modport slave (
    input  i_vsync, i_hsync, i_reuse, i_valid, i_tdata,
    output o_vsync, o_hsync, o_reuse, o_valid, o_window, o_ch, o_err
  );
endinterface

// File: rtl/chan_delay.sv
// Width x Depth shift register advancing only when en is high; dout is the entry Depth shifts old.
module chan_delay #(
  parameter int unsigned Width = 6,
  parameter int unsigned Depth = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (en) begin
      mem_q[0] <= din;
      for (int i = 1; i < Depth; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign dout = mem_q[Depth-1];

endmodule

// File: rtl/sign_window_3x3.sv
// Builds horizontally zero-padded 3x3 sign windows, one per (centre column, channel), from a
// channel-interleaved 3-row sign-column stream.
module sign_window_3x3
  import sign_win_pkg::*;
#(
  parameter int unsigned SIZE    = 56,
  parameter int unsigned CHANNEL = 64,
  parameter int unsigned LEN     = 3,
  parameter int unsigned CW      = $clog2(CHANNEL)
) (
  input logic              i_sclk,
  input logic              i_rstn,
  sign_window_3x3_if.slave bus
);

  localparam int unsigned CLW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned W   = 2 * LEN;
  localparam int unsigned WW  = 2 * LEN * LEN;
  localparam logic [CLW-1:0] ColLast = CLW'(SIZE - 1);
  localparam logic [CW-1:0]  ChLast  = CW'(CHANNEL - 1);

  state_e          state_q;
  logic [CLW-1:0]  col_q;
  logic [CW-1:0]   ch_q;
  logic            vsync_q, hsync_q, reuse_q, valid_q, err_q;
  logic [WW-1:0]   window_q;
  logic [CW-1:0]   och_q;

  logic            shift_en;
  logic [W-1:0]    d1_din, d1_out, d2_out;
  logic            left_zero, right_zero;
  logic [WW-1:0]   window_d;

  // Lines only move on beats that are consumed, or with zeros during flush.
  always_comb begin
    shift_en = 1'b0;
    if (!bus.i_vsync && !bus.i_hsync) begin
      shift_en = (state_q == FLUSH) ||
                 (((state_q == FILL) || (state_q == RUN)) && bus.i_valid);
    end
  end

  assign d1_din = (state_q == FLUSH) ? '0 : bus.i_tdata;

  chan_delay #(.Width(W), .Depth(CHANNEL)) u_d1 (
    .clk   (i_sclk),
    .rst_n (i_rstn),
    .en    (shift_en),
    .din   (d1_din),
    .dout  (d1_out)
  );

  chan_delay #(.Width(W), .Depth(CHANNEL)) u_d2 (
    .clk   (i_sclk),
    .rst_n (i_rstn),
    .en    (shift_en),
    .din   (d1_out),
    .dout  (d2_out)
  );

  assign left_zero  = (state_q == RUN) && (col_q == CLW'(1));
  assign right_zero = (state_q == FLUSH);

  always_comb begin
    window_d = '0;
    for (int r = 0; r < LEN; r++) begin
      window_d[2*(LEN*r)+:2]   = left_zero ? SGN_ZERO : sgn_clean(d2_out[2*r+:2]);
      window_d[2*(LEN*r+1)+:2] = sgn_clean(d1_out[2*r+:2]);
      window_d[2*(LEN*r+2)+:2] = right_zero ? SGN_ZERO : sgn_clean(bus.i_tdata[2*r+:2]);
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      col_q    <= '0;
      ch_q     <= '0;
      vsync_q  <= 1'b0;
      hsync_q  <= 1'b0;
      reuse_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      window_q <= '0;
      och_q    <= '0;
    end else begin
      vsync_q <= bus.i_vsync;
      valid_q <= 1'b0;
      hsync_q <= 1'b0;
      if (bus.i_vsync) begin
        state_q <= IDLE;
        col_q   <= '0;
        ch_q    <= '0;
      end else if (bus.i_hsync) begin
        state_q <= FILL;
        col_q   <= '0;
        ch_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: ;
          FILL: begin
            if (bus.i_valid) begin
              if (ch_q == ChLast) begin
                ch_q    <= '0;
                col_q   <= col_q + CLW'(1);
                state_q <= RUN;
              end else begin
                ch_q <= ch_q + CW'(1);
              end
            end
          end
          RUN: begin
            if (bus.i_valid) begin
              valid_q  <= 1'b1;
              hsync_q  <= (col_q == CLW'(1)) && (ch_q == '0);
              reuse_q  <= bus.i_reuse;
              window_q <= window_d;
              och_q    <= ch_q;
              if (ch_q == ChLast) begin
                ch_q <= '0;
                if (col_q == ColLast) begin
                  col_q   <= '0;
                  state_q <= FLUSH;
                end else begin
                  col_q <= col_q + CLW'(1);
                end
              end else begin
                ch_q <= ch_q + CW'(1);
              end
            end
          end
          FLUSH: begin
            valid_q  <= 1'b1;
            window_q <= window_d;
            och_q    <= ch_q;
            if (bus.i_valid) err_q <= 1'b1;
            if (ch_q == ChLast) begin
              ch_q    <= '0;
              state_q <= IDLE;
            end else begin
              ch_q <= ch_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_vsync  = vsync_q;
  assign bus.o_hsync  = hsync_q;
  assign bus.o_reuse  = reuse_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_window = window_q;
  assign bus.o_ch     = och_q;
  assign bus.o_err    = err_q;

endmodule

// File: tb/tb_sign_window_3x3.sv
// Randomised bench for sign_window_3x3 against a per-row image model of the padded 3x3 windows.
module tb_sign_window_3x3;

  localparam int unsigned SIZE    = 4;
  localparam int unsigned CHANNEL = 2;
  localparam int unsigned LEN     = 3;
  localparam int unsigned CW      = 1;
  localparam int unsigned W       = 2 * LEN;
  localparam int unsigned WW      = 2 * LEN * LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sign_window_3x3_if #(.CHANNEL(CHANNEL), .LEN(LEN), .CW(CW)) bus ();

  sign_window_3x3 #(.SIZE(SIZE), .CHANNEL(CHANNEL), .LEN(LEN), .CW(CW)) dut (
    .i_sclk (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [WW-1:0] win;
    logic [CW-1:0] ch;
    logic          hs;
    logic          re;
  } exp_t;

  exp_t         expq[$];
  exp_t         e;
  logic [W-1:0] img [SIZE][CHANNEL];
  logic         rs  [SIZE][CHANNEL];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [1:0] clean(input logic [1:0] c);
    return (c == 2'b10) ? 2'b00 : c;
  endfunction

  // Window centred on column x of the current image: zero outside the row on either side.
  function automatic logic [WW-1:0] win_at(input int x, input int c);
    logic [WW-1:0] w;
    logic [W-1:0]  lpix, mpix, rpix;
    w    = '0;
    mpix = img[x][c];
    lpix = '0;
    rpix = '0;
    if (x > 0) lpix = img[x-1][c];
    if (x < SIZE - 1) rpix = img[x+1][c];
    for (int r = 0; r < LEN; r++) begin
      w[2*(3*r)+:2]   = clean(lpix[2*r+:2]);
      w[2*(3*r+1)+:2] = clean(mpix[2*r+:2]);
      w[2*(3*r+2)+:2] = clean(rpix[2*r+:2]);
    end
    return w;
  endfunction

  function automatic exp_t mk(input int x, input int c, input logic re);
    exp_t t;
    t.win = win_at(x, c);
    t.ch  = CW'(c);
    t.hs  = (x == 0) && (c == 0);
    t.re  = re;
    return t;
  endfunction

  task automatic fill(input int mode);
    for (int x = 0; x < SIZE; x++) begin
      for (int c = 0; c < CHANNEL; c++) begin
        case (mode)
          0:       img[x][c] = 6'b010101;
          1:       img[x][c] = (c % 2 == 0) ? 6'b010101 : 6'b111111;
          default: img[x][c] = W'($urandom);
        endcase
        rs[x][c] = 1'($urandom);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one row (or its first nbeats beats) and queues every window that must come out.
  task automatic send_row(input int nbeats, input int gaps, input bit inj);
    int k;
    int cyc;
    int x;
    int c;
    for (int b = 0; b < nbeats; b++) begin
      x = b / CHANNEL;
      c = b % CHANNEL;
      if (x >= 1) expq.push_back(mk(x - 1, c, rs[x][c]));
    end
    if (nbeats == SIZE * CHANNEL) begin
      for (int cc = 0; cc < CHANNEL; cc++) expq.push_back(mk(SIZE - 1, cc, rs[SIZE-1][CHANNEL-1]));
    end
    bus.i_hsync = 1'b1;
    bus.i_valid = 1'b0;
    step();
    bus.i_hsync = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < nbeats) begin
      if ((gaps == 1 && cyc % 2 == 1) || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
        bus.i_valid = 1'b0;
        bus.i_tdata = W'($urandom);
        bus.i_reuse = 1'($urandom);
      end else begin
        bus.i_valid = 1'b1;
        bus.i_tdata = img[k / CHANNEL][k % CHANNEL];
        bus.i_reuse = rs[k / CHANNEL][k % CHANNEL];
        k++;
      end
      cyc++;
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_reuse = 1'($urandom);
    if (inj) begin
      bus.i_valid = 1'b1;
      bus.i_tdata = W'($urandom);
      step();
      bus.i_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expq.size() != 0; i++) step();
    for (int i = 0; i < CHANNEL + 2; i++) step();
    check("drain", 64'(expq.size()), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_valid) begin
        if (expq.size() == 0) begin
          check("extra_win", 64'(bus.o_valid), 0);
        end else begin
          e = expq.pop_front();
          check("window", 64'(bus.o_window), 64'(e.win));
          check("ch", 64'(bus.o_ch), 64'(e.ch));
          check("hsync", 64'(bus.o_hsync), 64'(e.hs));
          check("reuse", 64'(bus.o_reuse), 64'(e.re));
        end
      end else begin
        check("hsync_alone", 64'(bus.o_hsync), 0);
      end
    end
  end

  initial begin
    bus.i_vsync = 1'b0;
    bus.i_hsync = 1'b0;
    bus.i_reuse = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_tdata = '0;

    // Reset with arbitrary inputs toggling.
    for (int i = 0; i < 3; i++) begin
      bus.i_vsync = 1'($urandom);
      bus.i_hsync = 1'($urandom);
      bus.i_reuse = 1'($urandom);
      bus.i_valid = 1'($urandom);
      bus.i_tdata = W'($urandom);
      step();
      check("rst_vsync", 64'(bus.o_vsync), 0);
      check("rst_hsync", 64'(bus.o_hsync), 0);
      check("rst_reuse", 64'(bus.o_reuse), 0);
      check("rst_valid", 64'(bus.o_valid), 0);
      check("rst_window", 64'(bus.o_window), 0);
      check("rst_ch", 64'(bus.o_ch), 0);
      check("rst_err", 64'(bus.o_err), 0);
    end
    bus.i_vsync = 1'b0;
    bus.i_hsync = 1'b0;
    bus.i_valid = 1'b0;
    rst_n = 1'b1;
    step();
    step();

    // Contiguous uniform row, then the same with valid toggling.
    fill(0);
    send_row(SIZE * CHANNEL, 0, 0);
    drain();
    fill(0);
    send_row(SIZE * CHANNEL, 1, 0);
    drain();

    // A beat arriving on the first flush cycle is dropped and flagged.
    check("err_pre", 64'(bus.o_err), 0);
    fill(0);
    send_row(SIZE * CHANNEL, 0, 1);
    check("err_set", 64'(bus.o_err), 1);
    drain();

    // Frame restart in the middle of a row, then a clean row.
    fill(0);
    send_row(2 * CHANNEL + 1, 0, 0);
    bus.i_vsync = 1'b1;
    step();
    bus.i_vsync = 1'b0;
    check("vsync_out", 64'(bus.o_vsync), 1);
    step();
    check("vsync_kill", 64'(bus.o_valid), 0);
    check("vsync_drop", 64'(bus.o_vsync), 0);
    drain();
    check("err_keep", 64'(bus.o_err), 1);
    fill(0);
    send_row(SIZE * CHANNEL, 0, 0);
    drain();

    // Per-channel sign pattern, then random codes (including the unused code) with random gaps.
    fill(1);
    send_row(SIZE * CHANNEL, 2, 0);
    drain();
    for (int n = 0; n < 4; n++) begin
      fill(2);
      send_row(SIZE * CHANNEL, n % 3, 0);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
